counter_prescaler: RTL and testbench

- Programmable clock-enable generator that sits directly upstream of the wrapping counter.
- Produces a one-cycle strobe every DIV+1 enabled cycles; the strobe drives the counter's `ena` input.
- The divisor is reloaded through a valid/ready handshake. A new divisor takes effect only at a period boundary, so no period is ever truncated.
- A synchronous `sync` input realigns the phase.

---
 rtl/counter_prescaler.sv | 66 ++++++
 tb/tb_counter_prescaler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_prescaler.sv
// Programmable clock-enable generator feeding a wrapping counter's ena input.
// The divisor reloads through a valid/ready handshake and only takes effect at a period boundary.
module counter_prescaler #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             sync,
    input  logic             div_vld,
    output logic             div_rdy,
    input  logic [WIDTH-1:0] div_dat,
    output logic             stb,
    output logic [WIDTH-1:0] phase,
    output logic [WIDTH-1:0] div
);

    localparam logic       IDLE = 1'b0;
    localparam logic       PEND = 1'b1;
    localparam logic [WIDTH-1:0] RST_V = RESET_DIV[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             state;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] reload;
    logic             tc;
    logic             accept;

    assign reload  = (state == PEND) ? pending : div;
    assign tc      = run && (phase == '0) && !sync;
    assign accept  = div_vld && (state == IDLE);
    assign div_rdy = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= RST_V;
            div   <= RST_V;
            stb   <= 1'b0;
        end else if (sync || tc) begin
            phase <= reload;
            if (state == PEND)
                div <= pending;
            stb   <= tc;
        end else if (run) begin
            phase <= phase - ONE;
            stb   <= 1'b0;
        end else begin
            stb   <= 1'b0;
        end
    end

    // A value accepted on a boundary edge waits for the next boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pending <= '0;
        end else if (accept) begin
            state   <= PEND;
            pending <= div_dat;
        end else if (sync || tc) begin
            state   <= IDLE;
        end
    end

endmodule

// File: tb/tb_counter_prescaler.sv
// Directed bench for counter_prescaler (WIDTH=4, RESET_DIV=3).
// A second instance drives a small wrapping counter through its strobe.
module tb_counter_prescaler;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       sync;
    logic       div_vld;
    logic       div_rdy;
    logic [3:0] div_dat;
    logic       stb;
    logic [3:0] phase;
    logic [3:0] div;

    logic       run2;
    logic       rdy2;
    logic       stb2;
    logic [3:0] phase2;
    logic [3:0] div2;
    logic [3:0] cnt;

    int checks = 0;
    int errors = 0;
    int nstb;

    always #5 clk = ~clk;

    counter_prescaler #(.WIDTH(4), .RESET_DIV(3)) dut (
        .clk(clk), .rst(rst), .run(run), .sync(sync),
        .div_vld(div_vld), .div_rdy(div_rdy), .div_dat(div_dat),
        .stb(stb), .phase(phase), .div(div)
    );

    counter_prescaler #(.WIDTH(4), .RESET_DIV(3)) dut2 (
        .clk(clk), .rst(rst), .run(run2), .sync(1'b0),
        .div_vld(1'b0), .div_rdy(rdy2), .div_dat(4'd0),
        .stb(stb2), .phase(phase2), .div(div2)
    );

    // Downstream wrapping counter enabled by the second strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= 4'd0;
        else if (stb2) cnt <= cnt + 4'd1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; run = 1'b0; sync = 1'b0;
        div_vld = 1'b0; div_dat = 4'd0; run2 = 1'b0;
        #12;
        check("rst_div", div, 3);
        check("rst_phase", phase, 3);
        check("rst_stb", stb, 0);
        check("rst_rdy", div_rdy, 1);
        @(negedge clk);
        rst = 1'b1; run = 1'b1; run2 = 1'b1;

        // 1: free-running period of 4
        nstb = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("s1_phase", phase, 3 - (k % 4));
            check("s1_stb", stb, int'(k % 4 == 0));
            nstb += stb;
        end
        check("s1_count", nstb, 5);
        check("s1_cnt", cnt, 4);
        repeat (49) tick();
        check("s1_cnt_wrap", cnt, 1);
        run2 = 1'b0;

        // 2: load 0 while phase=2, then 5
        check("s2_phase", phase, 2);
        div_vld = 1'b1; div_dat = 4'd0;
        tick();
        check("s2_rdy_lo", div_rdy, 0);
        check("s2_phase1", phase, 1);
        div_dat = 4'd9;
        tick();
        check("s2_rdy_hold", div_rdy, 0);
        check("s2_div_old", div, 3);
        div_vld = 1'b0;
        tick();
        check("s2_div0", div, 0);
        check("s2_rdy_hi", div_rdy, 1);
        check("s2_stb_tc", stb, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("s2_stb_cont", stb, 1);
            check("s2_phase0", phase, 0);
        end
        div_vld = 1'b1; div_dat = 4'd5;
        tick();
        check("s2_div_still0", div, 0);
        check("s2_rdy5", div_rdy, 0);
        check("s2_stb5", stb, 1);
        div_vld = 1'b0;
        tick();
        check("s2_div5", div, 5);
        check("s2_phase5", phase, 5);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("s2_p6_phase", phase, (k == 6) ? 5 : 5 - k);
            check("s2_p6_stb", stb, int'(k == 6));
        end

        // 3: run low while phase=2
        repeat (3) tick();
        check("s3_phase", phase, 2);
        run = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("s3_hold_phase", phase, 2);
            check("s3_hold_stb", stb, 0);
        end
        run = 1'b1;
        tick();
        check("s3_p1", phase, 1);
        tick();
        check("s3_p0", phase, 0);
        check("s3_stb_early", stb, 0);
        tick();
        check("s3_stb", stb, 1);
        check("s3_reload", phase, 5);

        // 4: sync on a TC edge with pending=7
        div_vld = 1'b1; div_dat = 4'd7;
        tick();
        check("s4_rdy", div_rdy, 0);
        check("s4_phase4", phase, 4);
        div_vld = 1'b0;
        repeat (4) tick();
        check("s4_phase0", phase, 0);
        sync = 1'b1;
        tick();
        check("s4_sync_stb", stb, 0);
        check("s4_sync_phase", phase, 7);
        check("s4_sync_div", div, 7);
        check("s4_sync_rdy", div_rdy, 1);
        sync = 1'b0;
        repeat (7) tick();
        check("s4_phase0b", phase, 0);
        div_vld = 1'b1; div_dat = 4'd2;
        tick();
        check("s4_tc_stb", stb, 1);
        check("s4_tc_phase", phase, 7);
        check("s4_tc_div", div, 7);
        check("s4_tc_rdy", div_rdy, 0);
        div_vld = 1'b0;
        repeat (7) tick();
        check("s4_old_phase", phase, 0);
        check("s4_old_div", div, 7);
        tick();
        check("s4_new_stb", stb, 1);
        check("s4_new_phase", phase, 2);
        check("s4_new_div", div, 2);
        check("s4_new_rdy", div_rdy, 1);

        // 5: maximum divisor, then 0 followed by 15
        div_vld = 1'b1; div_dat = 4'd15;
        tick();
        check("s5_phase1", phase, 1);
        div_vld = 1'b0;
        tick();
        tick();
        check("s5_stb", stb, 1);
        check("s5_phase15", phase, 15);
        check("s5_div15", div, 15);
        nstb = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            nstb += stb;
            check("s5_phase", phase, (k == 16) ? 15 : 15 - k);
        end
        check("s5_end_stb", stb, 1);
        check("s5_period", nstb, 1);
        div_vld = 1'b1; div_dat = 4'd0;
        tick();
        check("s5_phase14", phase, 14);
        div_vld = 1'b0;
        repeat (14) tick();
        check("s5_phase0", phase, 0);
        tick();
        check("s5_d0_stb", stb, 1);
        check("s5_d0_div", div, 0);
        div_vld = 1'b1; div_dat = 4'd15;
        tick();
        check("s5_d0_stb2", stb, 1);
        check("s5_d0_rdy", div_rdy, 0);
        check("s5_d0_phase", phase, 0);
        div_vld = 1'b0;
        tick();
        check("s5_d15_stb", stb, 1);
        check("s5_d15_phase", phase, 15);
        check("s5_d15_div", div, 15);
        nstb = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            nstb += stb;
        end
        check("s5_d15_end", stb, 1);
        check("s5_d15_period", nstb, 1);
        check("s5_d15_wrap", phase, 15);

        // 6: async reset mid-period with pending=9
        div_vld = 1'b1; div_dat = 4'd9;
        tick();
        check("s6_rdy", div_rdy, 0);
        div_vld = 1'b0;
        repeat (13) tick();
        check("s6_phase1", phase, 1);
        #2;
        rst = 1'b0;
        #1;
        check("s6_stb", stb, 0);
        check("s6_phase", phase, 3);
        check("s6_div", div, 3);
        check("s6_rdy_hi", div_rdy, 1);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("s6_seq_phase", phase, 3 - (k % 4));
            check("s6_seq_stb", stb, int'(k % 4 == 0));
        end
        check("s6_div_kept", div, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
